// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller: blank code, FSM
// states and the leading-zero blanking helper.
package seg7_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         MAX_DIGITS = 8;
  localparam int         DISP_W     = 4 * MAX_DIGITS;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Digit k is blanked when every digit at positions >= k is zero; digit 0 is
  // never blanked. Callers zero-extend narrower displays, which keeps this exact.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [DISP_W-1:0] display,
                                                    input logic              lz_blank);
    logic                  all_zero;
    logic [MAX_DIGITS-1:0] mask;
    all_zero = 1'b1;
    mask     = '0;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero && (display[4*k +: 4] == 4'h0);
      mask[k]  = lz_blank && all_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a shared common-anode BCD decoder,
// with a tear-free display register and guard gaps between digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int GUARD_CYCLES    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    lz_blank,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int TMAX = (TICKS_PER_DIGIT > GUARD_CYCLES) ? TICKS_PER_DIGIT : GUARD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW   = 4 * NUM_DIGITS;

  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_CYCLES - 1);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] blank_mask;

  // Handshake: an update transfers on any rising edge where load_valid and
  // load_ready are both high. load_ready is a pure register (no pending update)
  // and never looks at load_valid; once asserted, the producer holds digits_in
  // until the transfer edge.
  assign load_ready = ~pend_valid_q;
  assign bcd_out    = bcd_q;
  assign frame_done = (state_q == SHOW) && (idx_q == IDX_LAST) && (timer_q == SHOW_LAST);

  always_comb begin
    an_n = '1;
    if (state_q == SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_q == IW'(k)) an_n[k] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TW'(1);
    idx_d        = idx_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    bcd_d        = bcd_q;
    boundary     = 1'b0;
    blank_mask   = '0;

    if (state_q == GUARD) begin
      if (timer_q == GUARD_LAST) begin
        state_d = SHOW;
        timer_d = '0;
      end
    end else if (timer_q == SHOW_LAST) begin
      state_d = GUARD;
      timer_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d    = '0;
        boundary = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    // Commit and accept are exclusive: accept needs an empty pending slot.
    if (boundary && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end
    if (load_valid && load_ready) begin
      pend_d       = digits_in;
      pend_valid_d = 1'b1;
    end

    // Reload the decoder code from the post-commit display so digit 0 of a
    // new frame already shows the new value.
    blank_mask = NUM_DIGITS'(lz_mask(DISP_W'(disp_d), lz_blank));
    if ((state_q == SHOW) && (state_d == GUARD)) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_d == IW'(k)) bcd_d = blank_mask[k] ? BLANK_CODE : disp_d[4*k +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= GUARD;
      timer_q      <= '0;
      idx_q        <= '0;
      disp_q       <= {NUM_DIGITS{BLANK_CODE}};
      pend_q       <= {NUM_DIGITS{BLANK_CODE}};
      pend_valid_q <= 1'b0;
      bcd_q        <= BLANK_CODE;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      bcd_q        <= bcd_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: table of load values with expected digit codes,
// plus hand-written boundary-accept and mid-scan reset sequences.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int T     = 4;
  localparam int G     = 1;
  localparam int FRAME = N * (G + T);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4*N-1:0] digits_in;
  logic         load_valid;
  logic         load_ready;
  logic         lz_blank;
  logic [3:0]   bcd_out;
  logic [N-1:0] an_n;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  // Each entry: {expected an_n, expected bcd_out} at the start of a SHOW interval.
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [15:0] codes;
  } vec_t;

  vec_t vecs[7];

  seg7_scan_ctrl #(
    .NUM_DIGITS     (N),
    .TICKS_PER_DIGIT(T),
    .GUARD_CYCLES   (G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .lz_blank  (lz_blank),
    .bcd_out   (bcd_out),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic push_codes(input logic [15:0] codes);
    for (int k = 0; k < N; k++) begin
      logic [3:0] an;
      an    = 4'hF;
      an[k] = 1'b0;
      exp_q.push_back({an, codes[4*k +: 4]});
    end
  endtask

  task automatic load(input logic [15:0] value);
    int guard_cnt;
    guard_cnt = 0;
    while (!load_ready && guard_cnt < 100) begin
      tick();
      guard_cnt++;
    end
    if (!load_ready) begin
      errors++;
      $display("FAIL load_ready_timeout actual=0 required=1");
    end
    digits_in  = value;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("ready_low_after_accept", load_ready, 1'b0);
  endtask

  task automatic wait_frame_done();
    int guard_cnt;
    guard_cnt = 0;
    while (!frame_done && guard_cnt < 100) begin
      tick();
      guard_cnt++;
    end
    if (!frame_done) begin
      errors++;
      $display("FAIL frame_done_timeout actual=0 required=1");
    end
  endtask

  task automatic drain();
    int guard_cnt;
    guard_cnt = 0;
    while (exp_q.size() > 0 && guard_cnt < 300) begin
      tick();
      guard_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard and per-cycle invariants
  logic [3:0] prev_an  = 4'hF;
  logic [3:0] prev_bcd = 4'hF;
  int         since_fd = 0;
  bit         fd_seen  = 1'b0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n !== 1'b1) fd_seen = 1'b0;
    since_fd++;
    check("an_n_onehot0", ($countones(~an_n) <= 1), 1'b1);
    if (an_n != 4'hF && an_n == prev_an) check("bcd_stable", bcd_out, prev_bcd);
    if (prev_an == 4'hF && an_n != 4'hF && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("show_digit", {an_n, bcd_out}, e);
    end
    if (frame_done === 1'b1) begin
      if (fd_seen) check("frame_period", since_fd, FRAME);
      fd_seen  = 1'b1;
      since_fd = 0;
    end
    prev_an  = an_n;
    prev_bcd = bcd_out;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 16'h1234};
    vecs[1] = '{16'h0050, 1'b1, 16'hFF50};
    vecs[2] = '{16'h0050, 1'b0, 16'h0050};
    vecs[3] = '{16'h0000, 1'b1, 16'hFFF0};
    vecs[4] = '{16'h0A05, 1'b1, 16'hFA05};
    vecs[5] = '{16'h1000, 1'b1, 16'h1000};
    vecs[6] = '{16'h0100, 1'b1, 16'hF100};

    rst_n      = 1'b0;
    digits_in  = '0;
    load_valid = 1'b0;
    lz_blank   = 1'b0;
    repeat (3) tick();

    check("reset_an_n", an_n, 4'hF);
    check("reset_bcd", bcd_out, 4'hF);
    check("reset_load_ready", load_ready, 1'b1);
    check("reset_frame_done", frame_done, 1'b0);

    // Blank scan after reset; first anode appears GUARD cycles after release
    push_codes(16'hFFFF);
    push_codes(16'hFFFF);
    rst_n = 1'b1;
    tick();
    check("first_anode", an_n, 4'b1110);
    drain();

    // Table-driven loads
    for (int v = 0; v < 7; v++) begin
      lz_blank = vecs[v].lz;
      load(vecs[v].value);
      wait_frame_done();
      check("ready_low_on_boundary", load_ready, 1'b0);
      push_codes(vecs[v].codes);
      tick();
      check("ready_high_after_boundary", load_ready, 1'b1);
      drain();
    end

    // Hold valid while not ready, then accept exactly on a boundary cycle
    lz_blank = 1'b0;
    load(16'h5678);
    digits_in  = 16'h1111;
    load_valid = 1'b1;
    wait_frame_done();
    push_codes(16'h5678);
    push_codes(16'h5678);
    push_codes(16'h2222);
    tick();
    load_valid = 1'b0;
    check("ready_after_commit", load_ready, 1'b1);
    tick();
    check("no_capture_while_busy", load_ready, 1'b1);
    wait_frame_done();
    check("ready_on_boundary_accept", load_ready, 1'b1);
    digits_in  = 16'h2222;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("ready_low_after_boundary_accept", load_ready, 1'b0);
    drain();

    // Reset mid-SHOW of digit 2 with an update pending
    wait_frame_done();
    tick();
    load(16'h9999);
    begin
      int guard_cnt;
      guard_cnt = 0;
      while (an_n != 4'b1011 && guard_cnt < 100) begin
        tick();
        guard_cnt++;
      end
      check("reach_digit2", an_n, 4'b1011);
    end
    tick();
    check("pending_before_reset", load_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    check("midreset_an_n", an_n, 4'hF);
    check("midreset_bcd", bcd_out, 4'hF);
    check("midreset_load_ready", load_ready, 1'b1);
    check("midreset_frame_done", frame_done, 1'b0);
    push_codes(16'hFFFF);
    push_codes(16'hFFFF);
    rst_n = 1'b1;
    tick();
    check("midreset_restart_digit0", an_n, 4'b1110);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
